// File: rtl/lb_wr_seq.sv
// Local-bus write sequencer: FIFO-buffered commands issued as one-cycle lb_write strobes, GAP idle cycles apart.
// Idle-to-strobe latency 2 cycles; cmd_ready is registered !full. Optional LB_WR_SEQ_COUNT_EN adds a saturating wr_count.
module lb_wr_seq #(
  parameter int FIFO_AW = 2,
  parameter int GAP     = 1
) (
  input  logic        lb_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [14:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_last,
  output logic [14:0] lb_addr,
  output logic [31:0] lb_data,
  output logic        lb_write,
  output logic        busy,
  output logic        done
`ifdef LB_WR_SEQ_COUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LP_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [3:0] LP_GAP = 4'(GAP);

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic        last;
  } ent_t;

  typedef enum logic {S_IDLE = 1'b0, S_GAP = 1'b1} state_t;

  ent_t               r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_fcnt;
  logic               r_rdy;
  state_t             r_state;
  logic [3:0]         r_gcnt;
  logic               r_lb_write;
  logic [14:0]        r_lb_addr;
  logic [31:0]        r_lb_data;
  logic               r_last;
  logic               r_done;

  logic               w_push;
  logic               w_pop;
  ent_t               w_head;
  logic [FIFO_AW:0]   w_fcnt_nxt;

  assign w_push     = cmd_valid & r_rdy;
  // The final GAP cycle may already launch the next entry, so lb_write stays low exactly GAP cycles.
  assign w_pop      = (r_fcnt != '0) && ((r_state == S_IDLE) || (r_gcnt == 4'd0));
  assign w_head     = r_mem[r_rptr];
  assign w_fcnt_nxt = r_fcnt + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);

  always_ff @(posedge lb_clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_addr, cmd_data, cmd_last};
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      r_rdy  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      r_fcnt <= w_fcnt_nxt;
      r_rdy  <= (w_fcnt_nxt != LP_FULL);
    end
  end

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gcnt     <= 4'd0;
      r_lb_write <= 1'b0;
      r_lb_addr  <= 15'd0;
      r_lb_data  <= 32'd0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_lb_write <= w_pop;
      r_done     <= r_lb_write & r_last;
      if (w_pop) begin
        r_lb_addr <= w_head.addr;
        r_lb_data <= w_head.data;
        r_last    <= w_head.last;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop && (GAP != 0)) begin
            r_state <= S_GAP;
            r_gcnt  <= LP_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt == 4'd0) begin
            if (w_pop) r_gcnt  <= LP_GAP;
            else       r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign cmd_ready = r_rdy;
  assign lb_addr   = r_lb_addr;
  assign lb_data   = r_lb_data;
  assign lb_write  = r_lb_write;
  assign done      = r_done;
  assign busy      = (r_fcnt != '0) | (r_state == S_GAP) | r_lb_write | r_done;

`ifdef LB_WR_SEQ_COUNT_EN
  logic [15:0] r_wr_count;

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n)                                   r_wr_count <= 16'd0;
    else if (r_lb_write && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
  end

  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_lb_wr_seq.sv
// Bench for lb_wr_seq: three instances (GAP 1, 0, 15) driven in turn; a negedge monitor checks each cycle
// against an occupancy/timing model derived from the acceptance and issue rules.
module tb_lb_wr_seq;

  localparam int NI    = 3;
  localparam int DEPTH = 4;
  localparam int GAPS [NI] = '{1, 0, 15};

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic        last;
  } ent_t;

  logic lb_clk = 1'b0;
  always #5 lb_clk = ~lb_clk;

  logic        rn  [NI];
  logic        cv  [NI];
  logic        rdy [NI];
  logic [14:0] ca  [NI];
  logic [31:0] cd  [NI];
  logic        cl  [NI];
  logic [14:0] la  [NI];
  logic [31:0] ld  [NI];
  logic        lw  [NI];
  logic        bsy [NI];
  logic        dn  [NI];
`ifdef LB_WR_SEQ_COUNT_EN
  logic [15:0] wc  [NI];
`endif

  int   n_vec = 0;
  int   n_bad = 0;
  ent_t exp_q [NI][$];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    lb_wr_seq #(.FIFO_AW(2), .GAP(GAPS[k])) u_dut (
      .lb_clk    (lb_clk),
      .rst_n     (rn[k]),
      .cmd_valid (cv[k]),
      .cmd_ready (rdy[k]),
      .cmd_addr  (ca[k]),
      .cmd_data  (cd[k]),
      .cmd_last  (cl[k]),
      .lb_addr   (la[k]),
      .lb_data   (ld[k]),
      .lb_write  (lw[k]),
      .busy      (bsy[k]),
      .done      (dn[k])
`ifdef LB_WR_SEQ_COUNT_EN
      ,
      .wr_count  (wc[k])
`endif
    );
  end

  task automatic chk(input string nm, input int k, input logic [47:0] got, input logic [47:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h time=%0t", nm, k, got, want, $time);
    end
  endtask

  // Monitor: model tracks queued entries and the last strobe cycle; expectations come from those alone.
  initial begin
    int   held [NI];
    int   accp [NI];
    int   lastw[NI];
    int   t    [NI];
    int   nw   [NI];
    logic pw   [NI];
    logic pl   [NI];
    logic ew, ed, eb, lnow;
    ent_t e;
    forever begin
      @(negedge lb_clk);
      for (int k = 0; k < NI; k++) begin
        if (!rn[k]) begin
          chk("rst_lb_write", k, 48'(lw[k]), 48'd0);
          chk("rst_cmd_ready", k, 48'(rdy[k]), 48'd0);
          chk("rst_busy", k, 48'(bsy[k]), 48'd0);
          chk("rst_done", k, 48'(dn[k]), 48'd0);
          chk("rst_lb_addr", k, 48'(la[k]), 48'd0);
          chk("rst_lb_data", k, 48'(ld[k]), 48'd0);
`ifdef LB_WR_SEQ_COUNT_EN
          chk("rst_wr_count", k, 48'(wc[k]), 48'd0);
`endif
          held[k] = 0; accp[k] = 0; lastw[k] = -1000; t[k] = 0; nw[k] = 0;
          pw[k] = 1'b0; pl[k] = 1'b0;
          exp_q[k].delete();
        end else begin
          lnow = 1'b0;
          ew = (held[k] > 0) && ((t[k] - 1 - lastw[k]) >= GAPS[k]);
          chk("lb_write", k, 48'(lw[k]), 48'(ew));
          if (lw[k]) begin
            if (exp_q[k].size() == 0) begin
              chk("spurious_write_q", k, 48'(exp_q[k].size()), 48'd1);
            end else begin
              e = exp_q[k].pop_front();
              chk("lb_addr", k, 48'(la[k]), 48'(e.addr));
              chk("lb_data", k, 48'(ld[k]), 48'(e.data));
              lnow = e.last;
            end
            lastw[k] = t[k];
          end
          ed = pw[k] && pl[k];
          chk("done", k, 48'(dn[k]), 48'(ed));
          held[k] = held[k] + accp[k] - int'(lw[k]);
          eb = (held[k] > 0) || lw[k] || ed ||
               ((t[k] - lastw[k]) >= 1 && (t[k] - lastw[k]) <= GAPS[k]);
          chk("busy", k, 48'(bsy[k]), 48'(eb));
          chk("cmd_ready", k, 48'(rdy[k]), 48'(held[k] < DEPTH));
`ifdef LB_WR_SEQ_COUNT_EN
          chk("wr_count", k, 48'(wc[k]), 48'((nw[k] > 65535) ? 65535 : nw[k]));
`endif
          if (lw[k]) nw[k]++;
          accp[k] = int'(cv[k] && rdy[k]);
          pw[k]   = lw[k];
          pl[k]   = lnow;
          t[k]++;
        end
      end
    end
  end

  task automatic send(input int k, input logic [14:0] a, input logic [31:0] d, input logic l);
    int   w  = 0;
    logic ok = 1'b0;
    cv[k] = 1'b1; ca[k] = a; cd[k] = d; cl[k] = l;
    while (!ok && w < 200) begin
      @(negedge lb_clk);
      ok = rdy[k];
      if (ok) exp_q[k].push_back({a, d, l});
      @(posedge lb_clk);
      #1;
      w++;
    end
    chk("send_accepted", k, 48'(ok), 48'd1);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int w = 0;
    cv[k] = 1'b0;
    while ((bsy[k] || exp_q[k].size() != 0) && w < budget) begin
      @(posedge lb_clk);
      #1;
      w++;
    end
    chk("drain_in_budget", k, 48'(bsy[k] || exp_q[k].size() != 0), 48'd0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rn[k] = 1'b0; cv[k] = 1'b0; ca[k] = 15'd0; cd[k] = 32'd0; cl[k] = 1'b0;
    end
    repeat (3) @(negedge lb_clk);
    #1;
    for (int k = 0; k < NI; k++) rn[k] = 1'b1;
    @(posedge lb_clk);
    #1;

    for (int k = 0; k < NI; k++) begin
      send(k, 15'h0405, 32'd60000, 1'b1);
      wait_idle(k, 40);

      for (int i = 0; i < 6; i++)
        send(k, 15'($urandom), $urandom, (i == 2) || (i == 5));
      wait_idle(k, 200);

      for (int i = 0; i < 20; i++) begin
        send(k, 15'($urandom), $urandom, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) begin
          cv[k] = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge lb_clk);
          #1;
        end
      end
      wait_idle(k, 600);

      // Reset while strobes are still queued: nothing may come out afterwards.
      for (int i = 0; i < 4; i++)
        send(k, 15'($urandom), $urandom, 1'b1);
      cv[k] = 1'b0;
      rn[k] = 1'b0;
      #1;
      chk("async_rst_lb_write", k, 48'(lw[k]), 48'd0);
      chk("async_rst_lb_addr", k, 48'(la[k]), 48'd0);
      chk("async_rst_lb_data", k, 48'(ld[k]), 48'd0);
      chk("async_rst_busy", k, 48'(bsy[k]), 48'd0);
      chk("async_rst_done", k, 48'(dn[k]), 48'd0);
      chk("async_rst_cmd_ready", k, 48'(rdy[k]), 48'd0);
      repeat (2) @(negedge lb_clk);
      #1;
      rn[k] = 1'b1;
      repeat (20 + GAPS[k]) @(posedge lb_clk);
      #1;
      wait_idle(k, 5);
    end

`ifdef LB_WR_SEQ_COUNT_EN
    for (int i = 0; i < 70000; i++)
      send(1, 15'($urandom), $urandom, 1'b0);
    wait_idle(1, 50);
    chk("wr_count_saturated", 1, 48'(wc[1]), 48'd65535);
`endif

    repeat (5) @(posedge lb_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
